// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer: turns one addr/rw/len command plus a TX byte stream into the
// transfer/byte handshake of a downstream I2C master, collecting read bytes in an RX FIFO.
module i2c_byte_sequencer #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             m_transfer_control,
  output logic             m_byte_control,
  output logic             m_read_write,
  output logic             m_combined_enable,
  output logic [6:0]       m_target_address,
  output logic [7:0]       m_data_in,
  input  logic [7:0]       m_data_out,
  input  logic             m_data_finish,
  input  logic             m_transfer_busy,
  input  logic             m_error,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // START  | transfer_control raised, waiting for master busy
  // WR     | feeding TX FIFO bytes to the master
  // RD     | collecting master bytes into the RX FIFO
  // STOP   | transfer_control dropped, waiting for master idle
  // DONE   | one-cycle done/err pulse
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WR    = 3'd2,
    S_RD    = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [6:0]       addr_q;
  logic             rw_q;
  logic [LEN_W-1:0] count_q;
  logic             abort_q;

  logic [7:0] tx_mem [DEPTH];
  logic [AW:0] tx_wptr, tx_rptr;
  logic [7:0] rx_mem [DEPTH];
  logic [AW:0] rx_wptr, rx_rptr;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic accept, xfer_open, abort_evt;
  logic wr_byte, rd_byte, last_byte;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);

  assign accept    = cmd_valid && (state == S_IDLE);
  assign xfer_open = (state == S_START) || (state == S_WR) || (state == S_RD);
  assign abort_evt = m_error && xfer_open;

  // An error in the same cycle as a byte completion wins; the byte is not counted.
  assign wr_byte   = (state == S_WR) && m_data_finish && !m_error && !tx_empty;
  assign rd_byte   = (state == S_RD) && m_data_finish && !m_error && !rx_full;
  assign last_byte = (count_q == LEN_W'(1));

  assign tx_push = tx_valid && !tx_full;
  assign tx_pop  = wr_byte;
  assign rx_push = rd_byte;
  assign rx_pop  = rx_ready && !rx_empty;

  // ---------------- TX FIFO ----------------
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      // Abort empties the FIFO entirely, including a byte pushed this same cycle.
      if (abort_evt)   tx_rptr <= tx_wptr + {{AW{1'b0}}, tx_push};
      else if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // ---------------- RX FIFO ----------------
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= m_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // ---------------- command registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rw_q    <= 1'b0;
      count_q <= '0;
      abort_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        rw_q    <= cmd_rw;
        count_q <= cmd_len;
        abort_q <= 1'b0;
      end else begin
        if ((wr_byte || rd_byte) && (count_q != '0)) count_q <= count_q - 1'b1;
        if (abort_evt) abort_q <= 1'b1;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        if (m_error)              state_nxt = S_STOP;
        else if (m_transfer_busy) begin
          if (count_q == '0) state_nxt = S_STOP;
          else if (rw_q)     state_nxt = S_RD;
          else               state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (m_error)                     state_nxt = S_STOP;
        else if (wr_byte && last_byte)   state_nxt = S_STOP;
      end
      S_RD: begin
        if (m_error)                     state_nxt = S_STOP;
        else if (rd_byte && last_byte)   state_nxt = S_STOP;
      end
      S_STOP: begin
        if (!m_transfer_busy) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready          = 1'b0;
    busy               = 1'b1;
    m_transfer_control = 1'b0;
    m_byte_control     = 1'b0;
    done               = 1'b0;
    err                = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_START: m_transfer_control = 1'b1;
      S_WR: begin
        m_transfer_control = 1'b1;
        m_byte_control     = !tx_empty;
      end
      S_RD: begin
        m_transfer_control = 1'b1;
        m_byte_control     = !rx_full;
      end
      S_STOP: ;
      S_DONE: begin
        done = !abort_q;
        err  = abort_q;
      end
      default: ;
    endcase
  end

  // Heads read as zero when empty so nothing stale is presented after reset or a flush.
  assign m_data_in         = tx_empty ? 8'h00 : tx_mem[tx_rptr[AW-1:0]];
  assign rx_data           = rx_empty ? 8'h00 : rx_mem[rx_rptr[AW-1:0]];
  assign tx_ready          = !tx_full;
  assign rx_valid          = !rx_empty;
  assign m_read_write      = rw_q;
  assign m_target_address  = addr_q;
  assign m_combined_enable = 1'b0;

endmodule
